// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared constants, clog2 helper and tag type for the multiplier arbiter
package mul_arb_pkg;
  localparam int NREQ_DEF = 4;
  localparam int MUL_LAT_DEF = 1;
  localparam int STAT_W = 16;
  localparam int ID_MAX = 3;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
  typedef struct packed {
    logic              valid;
    logic [ID_MAX-1:0] id;
  } tag_t;
endpackage

// File: rtl/mul_arbiter_rr_pick.sv
// rr_pick: combinational round-robin select starting at ptr
//   req  requests, ptr  search start index
//   gnt  one-hot winner, idx  encoded winner, any  some request present
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [2*N-1:0] dbl;
  logic [N-1:0] rot;
  int w;
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    w = 0;
    for (int k = N - 1; k >= 0; k--) if (rot[k]) w = k;
    w = (w + int'(ptr)) % N;
    idx = W'(w);
    any = |req;
    gnt = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sharing of one registered multiplier among NREQ requesters
//   clk, rst          clock, synchronous active-high reset
//   en                allow new grants; in-flight results still drain
//   req, a_in, b_in   per-requester request and packed operands
//   gnt               combinational one-hot grant
//   mul_a, mul_b      registered operands to the shared multiplier
//   mul_out           product returned by the multiplier, MUL_LAT cycles later
//   res_valid/id/data registered tagged result
//   MUL_ARBITER_STATS_EN adds stat_busy and per-requester stat_gnt counters
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int Nbits = 5,
  parameter int obits = 11,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int IDW = clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*(Nbits+1)-1:0] a_in,
  input  logic [NREQ*(Nbits+1)-1:0] b_in,
  output logic [NREQ-1:0]         gnt,
  output logic [Nbits:0]          mul_a,
  output logic [Nbits:0]          mul_b,
  input  logic [obits:0]          mul_out,
  output logic                    res_valid,
  output logic [IDW-1:0]          res_id,
  output logic [obits:0]          res_data
`ifdef MUL_ARBITER_STATS_EN
  ,
  output logic [STAT_W-1:0]       stat_busy,
  output logic [NREQ*STAT_W-1:0]  stat_gnt
`endif
);
  logic [IDW-1:0] ptr, win;
  logic [NREQ-1:0] pick;
  logic any, go;
  tag_t tag [MUL_LAT+1];
  rr_pick #(.N(NREQ), .W(IDW)) u_pick (
    .req(req),
    .ptr(ptr),
    .gnt(pick),
    .idx(win),
    .any(any)
  );
  // gnt is only ever raised on a requesting line, so go is the transfer condition
  always_comb begin
    go = en & ~rst & any;
    gnt = go ? pick : '0;
  end
  // the last tag stage lines up with mul_out from the operands loaded MUL_LAT cycles earlier
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      mul_a <= '0;
      mul_b <= '0;
      for (int s = 0; s <= MUL_LAT; s++) tag[s] <= '0;
      res_valid <= 1'b0;
      res_id <= '0;
      res_data <= '0;
    end else begin
      if (go) begin
        mul_a <= a_in[win*(Nbits+1) +: Nbits+1];
        mul_b <= b_in[win*(Nbits+1) +: Nbits+1];
        ptr <= IDW'((int'(win) + 1) % NREQ);
      end
      tag[0] <= '{valid: go, id: ID_MAX'(win)};
      for (int s = 1; s <= MUL_LAT; s++) tag[s] <= tag[s-1];
      res_valid <= tag[MUL_LAT].valid;
      res_id <= IDW'(tag[MUL_LAT].id);
      res_data <= mul_out;
    end
  end
`ifdef MUL_ARBITER_STATS_EN
  logic [STAT_W-1:0] busy;
  logic [NREQ*STAT_W-1:0] gcnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      gcnt <= '0;
    end else begin
      if (any && !go && busy != {STAT_W{1'b1}}) busy <= busy + 1'b1;
      for (int i = 0; i < NREQ; i++)
        if (gnt[i] && gcnt[i*STAT_W +: STAT_W] != {STAT_W{1'b1}})
          gcnt[i*STAT_W +: STAT_W] <= gcnt[i*STAT_W +: STAT_W] + 1'b1;
    end
  end
  assign stat_busy = busy;
  assign stat_gnt = gcnt;
`endif
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed scoreboard bench for mul_arbiter with a registered multiplier model
module tb_mul_arbiter;
  logic clk = 0, rst = 1, en = 0;
  logic [3:0] req = '0;
  logic [23:0] a_in = '0, b_in = '0;
  logic [3:0] gnt;
  logic [5:0] mul_a, mul_b;
  logic [11:0] mul_out;
  logic res_valid;
  logic [1:0] res_id;
  logic [11:0] res_data;
`ifdef MUL_ARBITER_STATS_EN
  logic [15:0] stat_busy;
  logic [63:0] stat_gnt;
`endif
  int checks = 0, failures = 0;
  typedef struct packed {
    logic [1:0]  id;
    logic [11:0] p;
  } exp_t;
  exp_t q[$];
  int mptr = 0;

  mul_arbiter dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data)
`ifdef MUL_ARBITER_STATS_EN
    , .stat_busy(stat_busy), .stat_gnt(stat_gnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) mul_out <= rst ? 12'd0 : 12'({6'd0, mul_a} * {6'd0, mul_b});

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  function automatic logic [3:0] model_gnt();
    if (rst || !en || req == 4'd0) return 4'd0;
    return 4'd1 << rr(req, mptr);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mptr = 0;
      q.delete();
    end else if (en && req != 4'd0) begin
      automatic int w = rr(req, mptr);
      automatic int p = int'(a_in[w*6 +: 6]) * int'(b_in[w*6 +: 6]);
      q.push_back('{id: 2'(w), p: 12'(p)});
      mptr = (w + 1) % 4;
    end
  end

  always @(negedge clk) begin
    check("gnt_model", 64'(gnt), 64'(model_gnt()));
    if (res_valid) begin
      if (q.size() == 0) check("unexpected_res_valid", 64'(res_valid), 64'd0);
      else begin
        automatic exp_t e = q.pop_front();
        check("sb_res_id", 64'(res_id), 64'(e.id));
        check("sb_res_data", 64'(res_data), 64'(e.p));
      end
    end
  end

  task automatic setop(input int i, input int a, input int b);
    a_in[i*6 +: 6] = 6'(a);
    b_in[i*6 +: 6] = 6'(b);
  endtask

  task automatic drive(input logic [3:0] r, input logic e);
    @(posedge clk);
    #1;
    req = r;
    en = e;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(4'd0, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1;
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 64'(gnt), 0);
    check("rst_mul_a", 64'(mul_a), 0);
    check("rst_mul_b", 64'(mul_b), 0);
    check("rst_res_valid", 64'(res_valid), 0);
    check("rst_res_id", 64'(res_id), 0);
    check("rst_res_data", 64'(res_data), 0);
    rst = 0;
    setop(1, 3, 5);
    drive(4'b0010, 1'b1);
    #1 check("t1_gnt", 64'(gnt), 64'h2);
    drive(4'b0000, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("t1_res_valid", 64'(res_valid), 1);
    check("t1_res_id", 64'(res_id), 1);
    check("t1_res_data", 64'(res_data), 15);
    setop(0, 2, 9);
    setop(3, 7, 6);
    drive(4'b1001, 1'b1);
    #1 check("t3_gnt_first", 64'(gnt), 64'h8);
    drive(4'b1001, 1'b1);
    #1 check("t3_gnt_second", 64'(gnt), 64'h1);
    idle(4);
    do_reset();
    for (int i = 0; i < 4; i++) setop(i, 10 + 3 * i, 20 + i);
    drive(4'b1111, 1'b1);
    for (int k = 0; k < 8; k++) begin
      #1 check("t2_gnt_order", 64'(gnt), 64'(4'd1 << (k % 4)));
      if (k < 7) drive(4'b1111, 1'b1);
    end
    idle(4);
`ifdef MUL_ARBITER_STATS_EN
    check("stat_gnt", 64'(stat_gnt), 64'h0002_0002_0002_0002);
`endif
    setop(0, 63, 63);
    drive(4'b0001, 1'b1);
    #1 check("t6_gnt", 64'(gnt), 64'h1);
    drive(4'b0000, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("t6_res_valid", 64'(res_valid), 1);
    check("t6_res_data", 64'(res_data), 3969);
    idle(2);
    setop(2, 7, 9);
    for (int k = 0; k < 3; k++) begin
      drive(4'b0100, 1'b0);
      #1;
      check("t5_gnt_off", 64'(gnt), 0);
      check("t5_mul_a_hold", 64'(mul_a), 63);
      check("t5_mul_b_hold", 64'(mul_b), 63);
    end
    drive(4'b0100, 1'b1);
    #1 check("t5_gnt_on", 64'(gnt), 64'h4);
    drive(4'b0000, 1'b1);
    #1 check("t5_mul_a_load", 64'(mul_a), 7);
    idle(3);
`ifdef MUL_ARBITER_STATS_EN
    check("stat_busy", 64'(stat_busy), 3);
`endif
    setop(3, 4, 4);
    drive(4'b1000, 1'b1);
    #1 check("t4_gnt", 64'(gnt), 64'h8);
    @(posedge clk);
    #1;
    rst = 1;
    req = '0;
    @(posedge clk);
    #1;
    check("t4_gnt", 64'(gnt), 0);
    check("t4_mul_a", 64'(mul_a), 0);
    check("t4_mul_b", 64'(mul_b), 0);
    check("t4_res_valid", 64'(res_valid), 0);
    check("t4_res_id", 64'(res_id), 0);
    check("t4_res_data", 64'(res_data), 0);
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1 check("t4_no_res_valid", 64'(res_valid), 0);
    end
    check("sb_drained", 64'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
